time_set_controller: RTL
========================

// Module: time_set_controller
// PURPOSE
//  Sequences the time-of-day counter: lets the user set hours and minutes with two buttons.
//  Sits between debounced front-panel buttons and the Digital_Clock counter: freezes it while setting,
//  then commits the new time with a one-cycle load; seconds restart at 0.
// PARAMETERS
//  HOUR_MAX     23  highest hour value; increment wraps HOUR_MAX -> 0
//  MIN_MAX      59  highest minute value; increment wraps MIN_MAX -> 0
//  TIMEOUT_SEC  30  idle 1 s ticks before a set is abandoned (used only with SET_TIMEOUT_EN)
// PORTS
//  Clk           in   1  system clock; every flop uses it
//  reset         in   1  asynchronous, active-high reset
//  tick_1sec     in   1  one-Clk-cycle strobe, once per second
//  btn_mode      in   1  debounced level, mode button
//  btn_inc       in   1  debounced level, increment button
//  cur_hours     in   5  live hours from the clock counter
//  cur_minutes   in   6  live minutes from the clock counter
//  clk_run_en    out  1  1 = counter may advance; 0 = counter frozen
//  load          out  1  one-cycle pulse: counter takes load_* values, seconds <= 0
//  load_hours    out  5  hours value to load
//  load_minutes  out  6  minutes value to load
//  mode          out  2  current state encoding (for display)
//  blink         out  1  toggles on tick_1sec while setting; drives the display blink
// BEHAVIOUR
//  Reset (async, any state): state=RUN, clk_run_en=1, load=0, load_hours=0, load_minutes=0, blink=0,
//   edge-detector history=0, timeout count=0. A set in progress is discarded, no load issued.
//  Buttons act on rising edges only (registered previous level); holding a button has no further effect.
//  States (mode encoding): RUN=0, SET_HR=1, SET_MIN=2, COMMIT=3.
//   RUN:     clk_run_en=1, blink=0. Mode edge -> SET_HR; shadow hrs/min <= cur_hours/cur_minutes same cycle.
//   SET_HR:  clk_run_en=0. Inc edge -> shadow hrs +1, HOUR_MAX wraps to 0. Mode edge -> SET_MIN.
//   SET_MIN: clk_run_en=0. Inc edge -> shadow min +1, MIN_MAX wraps to 0. Mode edge -> COMMIT.
//   COMMIT:  exactly one cycle; load=1, clk_run_en=0; next cycle RUN with clk_run_en=1.
//  load_hours/load_minutes always drive the shadow registers; they are valid whenever load=1.
//  Inc in RUN or COMMIT: ignored. Mode and inc edges in the same cycle: mode wins, inc dropped.
//  tick_1sec coincident with a button edge: both take effect (blink toggles, button handled).
//  blink: toggles on each tick_1sec in SET_HR/SET_MIN; cleared to 0 on entry to RUN.
//  Shadow arithmetic: widths match ports; increment is compare-to-MAX then 0, never modulo overflow.
//  A shadow value above MAX on entry (corrupt input) wraps to 0 on the next inc.
// CONFIGURATION
//  SET_TIMEOUT_EN defined: in SET_HR/SET_MIN an idle counter counts tick_1sec, cleared by any button edge;
//   reaching TIMEOUT_SEC -> RUN without load (original time resumes; no correction for the frozen time).
//  SET_TIMEOUT_EN undefined: no counter logic; SET states are left only via the mode button or reset.
// STRUCTURE
//  clock_ctrl_defs.vh (shared include): state encodings RUN/SET_HR/SET_MIN/COMMIT, HOUR_MAX/MIN_MAX
//   defaults and widths (5-bit hours, 6-bit minutes); also included by the clock counter.
//  Sub-module rise_edge: 1-bit rising-edge detector (level in, one-cycle pulse out, async reset),
//   instanced twice (btn_mode, btn_inc).
// TESTING
//  1 Reset asserted mid SET_MIN with shadow min=17 -> immediately mode=0, clk_run_en=1, load never pulses.
//  2 cur=10:45; mode, inc x3, mode, inc x2, mode -> one load pulse with 13:47; mode=0 next cycle.
//  3 In SET_HR from 22, inc x2 -> 23 then 0; in SET_MIN from 58, inc x2 -> 59 then 0.
//  4 Mode and inc rise in the same cycle in SET_HR -> enters SET_MIN, shadow hours unchanged.
//  5 Hold btn_inc high 10 ticks in SET_HR -> exactly one increment; blink toggles 10 times.
//  6 SET_TIMEOUT_EN, TIMEOUT_SEC=3: enter SET_HR, 3 idle ticks -> RUN, no load; without macro stays SET_HR.

Source files
------------

// File: rtl/time_set_controller_pkg.sv
// Shared definitions for the time-of-day set controller.
//  - set_state_e : controller states; the numeric values are also the
//                  'mode' display encoding (RUN=0, SET_HR=1, SET_MIN=2, COMMIT=3)
//  - HR_W/MIN_W  : hours / minutes field widths, matching the clock counter
//  - *_MAX_DEF   : default wrap points for the hour / minute increment
package time_set_controller_pkg;

   localparam int HR_W         = 5;
   localparam int MIN_W        = 6;
   localparam int HOUR_MAX_DEF = 23;
   localparam int MIN_MAX_DEF  = 59;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2,
      COMMIT  = 2'd3
   } set_state_e;

endpackage

// File: rtl/time_set_controller_rise_edge.sv
// rise_edge: 1-bit rising-edge detector.
//  Clk   in  clock
//  reset in  asynchronous, active-high reset (history cleared to 0)
//  level in  debounced level
//  pulse out high for the one cycle in which level is 1 and was 0 last cycle
module rise_edge (
   input  logic Clk,
   input  logic reset,
   input  logic level,
   output logic pulse
);

   logic prev_q;

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) prev_q <= 1'b0;
      else       prev_q <= level;
   end

   assign pulse = level & ~prev_q;

endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: lets the user set hours/minutes with a mode and an
// increment button. Freezes the clock counter while setting, then commits
// the shadow time with a one-cycle load.
//  Clk, reset              clock, asynchronous active-high reset
//  tick_1sec               one-cycle strobe once per second
//  btn_mode, btn_inc       debounced button levels (acted on at rising edges)
//  cur_hours, cur_minutes  live time from the counter, captured on entry
//  clk_run_en              1 = counter may advance
//  load                    one-cycle pulse, counter takes load_* (seconds <= 0)
//  load_hours/minutes      shadow registers being edited
//  mode                    current state for the display
//  blink                   toggles on tick_1sec while setting
// Optional build macro SET_TIMEOUT_EN: abandon a set (return to RUN without
// load) after TIMEOUT_SEC idle seconds in SET_HR/SET_MIN.
module time_set_controller
   import time_set_controller_pkg::*;
#(
   parameter int HOUR_MAX    = HOUR_MAX_DEF,
   parameter int MIN_MAX     = MIN_MAX_DEF,
   parameter int TIMEOUT_SEC = 30
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             tick_1sec,
   input  logic             btn_mode,
   input  logic             btn_inc,
   input  logic [HR_W-1:0]  cur_hours,
   input  logic [MIN_W-1:0] cur_minutes,
   output logic             clk_run_en,
   output logic             load,
   output logic [HR_W-1:0]  load_hours,
   output logic [MIN_W-1:0] load_minutes,
   output logic [1:0]       mode,
   output logic             blink
);

   localparam int NUM_BTN  = 2;
   localparam int BTN_MODE = 0;
   localparam int BTN_INC  = 1;

   localparam logic [HR_W-1:0]  HR_MAX_V  = HR_W'(HOUR_MAX);
   localparam logic [MIN_W-1:0] MIN_MAX_V = MIN_W'(MIN_MAX);

   logic [NUM_BTN-1:0] btn_lvl, btn_edge;
   logic               mode_edge, inc_edge;

   set_state_e         state_q, state_d;
   logic [HR_W-1:0]    hrs_q, hrs_d, hrs_inc;
   logic [MIN_W-1:0]   min_q, min_d, min_inc;
   logic               blink_q, blink_d;
   logic               timeout;

   // ---------------- button edge detectors ----------------
   assign btn_lvl = {btn_inc, btn_mode};

   generate
      for (genvar i = 0; i < NUM_BTN; i++) begin : g_edge
         rise_edge u_edge (
            .Clk   (Clk),
            .reset (reset),
            .level (btn_lvl[i]),
            .pulse (btn_edge[i])
         );
      end
   endgenerate

   assign mode_edge = btn_edge[BTN_MODE];
   assign inc_edge  = btn_edge[BTN_INC];

   // Compare-then-zero so a corrupt value above MAX also wraps to 0.
   assign hrs_inc = (hrs_q >= HR_MAX_V)  ? '0 : hrs_q + 1'b1;
   assign min_inc = (min_q >= MIN_MAX_V) ? '0 : min_q + 1'b1;

   // ---------------- optional idle timeout ----------------
`ifdef SET_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_SEC + 1);

   logic [TO_W-1:0] idle_q, idle_d;

   always_comb begin
      idle_d  = '0;
      timeout = 1'b0;
      if (state_q == SET_HR || state_q == SET_MIN) begin
         idle_d = idle_q;
         if (|btn_edge) begin
            idle_d = '0;
         end else if (tick_1sec) begin
            // Fires on the tick that makes the count reach TIMEOUT_SEC.
            if (idle_q == TO_W'(TIMEOUT_SEC - 1)) timeout = 1'b1;
            else                                  idle_d  = idle_q + 1'b1;
         end
         if (timeout) idle_d = '0;
      end
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) idle_q <= '0;
      else       idle_q <= idle_d;
   end
`else
   assign timeout = 1'b0;
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         hrs_q   <= '0;
         min_q   <= '0;
         blink_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hrs_q   <= hrs_d;
         min_q   <= min_d;
         blink_q <= blink_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hrs_d      = hrs_q;
      min_d      = min_q;
      blink_d    = blink_q;
      clk_run_en = 1'b0;
      load       = 1'b0;
      case (state_q)
         RUN: begin
            clk_run_en = 1'b1;
            if (mode_edge) begin
               state_d = SET_HR;
               hrs_d   = cur_hours;
               min_d   = cur_minutes;
            end
         end
         SET_HR: begin
            if (tick_1sec) blink_d = ~blink_q;
            // Mode has priority: a simultaneous inc edge is dropped.
            if (mode_edge)     state_d = SET_MIN;
            else if (timeout)  state_d = RUN;
            else if (inc_edge) hrs_d   = hrs_inc;
         end
         SET_MIN: begin
            if (tick_1sec) blink_d = ~blink_q;
            if (mode_edge)     state_d = COMMIT;
            else if (timeout)  state_d = RUN;
            else if (inc_edge) min_d   = min_inc;
         end
         COMMIT: begin
            load    = 1'b1;
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      if (state_d == RUN) blink_d = 1'b0;
   end

   assign mode         = state_q;
   assign load_hours   = hrs_q;
   assign load_minutes = min_q;
   assign blink        = blink_q;

endmodule
